// File: rtl/sim_config_if.sv
// sim_config_if: keypad-in / settings-out bus between the keypad encoder, sim_config_ctrl and the simulation core
interface sim_config_if #(
  parameter int NUM_SETTINGS = 3,
  parameter int VAL_W = 6
);
  localparam int SW = $clog2(NUM_SETTINGS);
  logic [3:0] buttonBus;
  logic pressed;
  logic [NUM_SETTINGS*VAL_W-1:0] maxVals;
  logic [1:0] simState;
  logic [SW-1:0] setting;
  logic [VAL_W-1:0] entry;
  logic [NUM_SETTINGS*VAL_W-1:0] values;
  logic commit;
  logic [SW-1:0] commitIdx;
  modport master (
    output buttonBus, pressed, maxVals,
    input simState, setting, entry, values, commit, commitIdx
  );
  modport slave (
    input buttonBus, pressed, maxVals,
    output simState, setting, entry, values, commit, commitIdx
  );
endinterface

// File: rtl/sim_config_ctrl.sv
// sim_config_ctrl: keypad run-state FSM with decimal entry into a clamped settings bank; define AUTO_RESTART_EN for the ENDING timeout
module sim_config_ctrl #(
  parameter int NUM_SETTINGS = 3,
  parameter int VAL_W = 6,
  parameter int MAX_DIGITS = 2,
  parameter logic [NUM_SETTINGS-1:0] LIVE_MASK = 3'b100,
  parameter logic [NUM_SETTINGS*VAL_W-1:0] RESET_VALS = '0,
  parameter int TIMEOUT = 1000
) (
  input logic clk,
  input logic rst,
  sim_config_if.slave bus
);
  localparam int SW = $clog2(NUM_SETTINGS);
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int XW = VAL_W + 4;
  localparam logic [1:0] S_START = 2'd0, S_SIM = 2'd1, S_PAUSE = 2'd2, S_END = 2'd3;
  localparam logic [3:0] K_STOP = 4'hA, K_RES = 4'hB, K_UP = 4'hC, K_DN = 4'hD, K_ESC = 4'hE, K_ENT = 4'hF;
  logic pressed_q, armed, ev, ed, dig_ok, wr, clr, to, commit_q;
  logic [3:0] key;
  logic [1:0] st, st_fsm, st_n;
  logic [SW-1:0] sel, sel_up, sel_dn, idx_q;
  logic [VAL_W-1:0] ent, lim, wval;
  logic [CW-1:0] cnt;
  logic [XW-1:0] cand;
  logic [NUM_SETTINGS*VAL_W-1:0] vals;
  // armed blocks a key held across reset from producing an event until it is released
  always_comb begin
    key = bus.buttonBus;
    ev = bus.pressed & ~pressed_q & armed;
    ed = (st == S_START) | ((st == S_PAUSE) & LIVE_MASK[sel]);
    cand = XW'(ent) * XW'(10) + XW'(key);
    dig_ok = ev & (key < 4'd10) & ed & (cand <= XW'(2 ** VAL_W - 1)) & (cnt < CW'(MAX_DIGITS));
    wr = ev & (key == K_ENT) & ed;
    lim = bus.maxVals[sel*VAL_W +: VAL_W];
    wval = ent < lim ? ent : lim;
    sel_up = sel == SW'(NUM_SETTINGS - 1) ? '0 : sel + 1'b1;
    sel_dn = sel == '0 ? SW'(NUM_SETTINGS - 1) : sel - 1'b1;
    st_fsm = !ev ? st :
             (st == S_START && key == K_RES) ? S_SIM :
             (st == S_SIM && key == K_STOP) ? S_PAUSE :
             (st == S_PAUSE && key == K_RES) ? S_SIM :
             (st == S_PAUSE && key == K_STOP) ? S_END :
             (st == S_END && key == K_RES) ? S_START : st;
    st_n = to ? S_START : st_fsm;
    clr = (ev & (key == K_ENT || key == K_ESC || key == K_UP || key == K_DN)) | (st_n != st);
  end
  // state, selection, entry accumulator and settings bank, all advanced on press events
  always_ff @(posedge clk) begin
    if (rst) begin
      pressed_q <= 1'b0;
      armed <= 1'b0;
      st <= S_START;
      sel <= '0;
      ent <= '0;
      cnt <= '0;
      vals <= RESET_VALS;
      commit_q <= 1'b0;
      idx_q <= '0;
    end else begin
      pressed_q <= bus.pressed;
      armed <= armed | ~bus.pressed;
      st <= st_n;
      sel <= (ev && key == K_UP) ? sel_up : (ev && key == K_DN) ? sel_dn : sel;
      ent <= clr ? '0 : dig_ok ? cand[VAL_W-1:0] : ent;
      cnt <= clr ? '0 : dig_ok ? cnt + 1'b1 : cnt;
      commit_q <= wr;
      if (wr) begin
        idx_q <= sel;
        vals[sel*VAL_W +: VAL_W] <= wval;
      end
    end
  end
`ifdef AUTO_RESTART_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  // cycles spent in ENDING since entry or the last event; zero elsewhere
  always_ff @(posedge clk) begin
    if (rst) tcnt <= '0;
    else tcnt <= (st != S_END || ev) ? '0 : tcnt + 1'b1;
  end
  assign to = (st == S_END) && !ev && (tcnt == TW'(TIMEOUT - 1));
`else
  assign to = (TIMEOUT < 0);
`endif
  assign bus.simState = st;
  assign bus.setting = sel;
  assign bus.entry = ent;
  assign bus.values = vals;
  assign bus.commit = commit_q;
  assign bus.commitIdx = idx_q;
endmodule

// File: tb/tb_sim_config_ctrl.sv
// tb_sim_config_ctrl: directed and randomized keypad scenarios checked against a behavioural model of sim_config_ctrl
module tb_sim_config_ctrl;
  localparam int N = 3, VW = 6, MD = 2, TO = 1000;
  localparam logic [2:0] LIVE = 3'b100;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, failures = 0;
  int m_st, m_sel, m_ent, m_cnt, m_idx;
  int m_vals [N];
  int mx [N];
  logic m_commit;
  sim_config_if #(.NUM_SETTINGS(N), .VAL_W(VW)) bus ();
  sim_config_ctrl #(.NUM_SETTINGS(N), .VAL_W(VW), .MAX_DIGITS(MD), .LIVE_MASK(LIVE), .RESET_VALS('0), .TIMEOUT(TO))
    dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic set_max();
    for (int i = 0; i < N; i++) bus.maxVals[i*VW +: VW] = VW'(mx[i]);
  endtask

  task automatic m_reset();
    m_st = 0; m_sel = 0; m_ent = 0; m_cnt = 0; m_idx = 0; m_commit = 0;
    for (int i = 0; i < N; i++) m_vals[i] = 0;
  endtask

  task automatic m_event(input int k);
    int old;
    bit ed, clr;
    old = m_st;
    ed = (m_st == 0) || (m_st == 2 && LIVE[m_sel]);
    clr = 0;
    m_commit = 0;
    if (k < 10) begin
      if (ed && m_cnt < MD && m_ent * 10 + k < (1 << VW)) begin
        m_ent = m_ent * 10 + k;
        m_cnt++;
      end
    end else if (k == 10) m_st = m_st == 1 ? 2 : m_st == 2 ? 3 : m_st;
    else if (k == 11) m_st = (m_st == 0 || m_st == 2) ? 1 : m_st == 3 ? 0 : m_st;
    else begin
      clr = 1;
      if (k == 12) m_sel = (m_sel + 1) % N;
      if (k == 13) m_sel = (m_sel + N - 1) % N;
      if (k == 15 && ed) begin
        m_vals[m_sel] = m_ent < mx[m_sel] ? m_ent : mx[m_sel];
        m_commit = 1;
        m_idx = m_sel;
      end
    end
    if (clr || m_st != old) begin m_ent = 0; m_cnt = 0; end
  endtask

  // c: commit right after the event edge; c2: commit one cycle later
  task automatic press(input int k, input int hold, input int gap, output logic c, output logic c2);
    @(negedge clk);
    bus.buttonBus = 4'(k);
    bus.pressed = 1'b1;
    @(posedge clk); #1;
    c = bus.commit;
    m_event(k);
    repeat (hold - 1) @(posedge clk);
    @(negedge clk);
    bus.pressed = 1'b0;
    @(posedge clk); #1;
    c2 = bus.commit;
    repeat (gap - 1) @(posedge clk);
  endtask

  task automatic test_reset();
    bus.pressed = 1'b0; bus.buttonBus = '0;
    for (int i = 0; i < N; i++) mx[i] = 63;
    set_max();
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++; if (bus.commit !== 1'b0) begin failures++; $display("FAIL reset_commit got=%0d exp=0", bus.commit); end
    @(negedge clk); rst = 1'b0; m_reset();
    @(posedge clk); #1;
    checks++; if (bus.simState !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.simState); end
    checks++; if (bus.setting !== 2'd0) begin failures++; $display("FAIL reset_setting got=%0d exp=0", bus.setting); end
    checks++; if (bus.entry !== 6'd0) begin failures++; $display("FAIL reset_entry got=%0d exp=0", bus.entry); end
    checks++; if (bus.values !== 18'd0) begin failures++; $display("FAIL reset_values got=%h exp=0", bus.values); end
    checks++; if (bus.commitIdx !== 2'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", bus.commitIdx); end
  endtask

  task automatic test_entry();
    logic c, c2;
    press(4, 1, 1, c, c2);
    press(2, 1, 1, c, c2);
    checks++; if (bus.entry !== 6'd42) begin failures++; $display("FAIL entry_42 got=%0d exp=42", bus.entry); end
    press(15, 1, 1, c, c2);
    checks++; if (bus.values[5:0] !== 6'd42) begin failures++; $display("FAIL commit_val got=%0d exp=42", bus.values[5:0]); end
    checks++; if (c !== 1'b1 || c2 !== 1'b0) begin failures++; $display("FAIL commit_pulse got=%b%b exp=10", c, c2); end
    checks++; if (bus.commitIdx !== 2'd0) begin failures++; $display("FAIL commit_idx got=%0d exp=0", bus.commitIdx); end
    checks++; if (bus.entry !== 6'd0) begin failures++; $display("FAIL entry_clear got=%0d exp=0", bus.entry); end
  endtask

  task automatic test_hold();
    logic c, c2;
    press(7, 20, 1, c, c2);
    checks++; if (bus.entry !== 6'd7) begin failures++; $display("FAIL hold_once got=%0d exp=7", bus.entry); end
    press(7, 1, 1, c, c2);
    checks++; if (bus.entry !== 6'd7) begin failures++; $display("FAIL entry_sat got=%0d exp=7", bus.entry); end
    press(14, 1, 1, c, c2);
    checks++; if (bus.entry !== 6'd0 || c !== 1'b0) begin failures++; $display("FAIL escape got=%0d/%b exp=0/0", bus.entry, c); end
  endtask

  task automatic test_clamp();
    logic c, c2;
    mx[2] = 7; set_max();
    press(12, 1, 1, c, c2);
    press(12, 1, 1, c, c2);
    checks++; if (bus.setting !== 2'd2) begin failures++; $display("FAIL sel_up2 got=%0d exp=2", bus.setting); end
    press(9, 1, 1, c, c2);
    press(15, 1, 1, c, c2);
    checks++; if (bus.values[17:12] !== 6'd7 || c !== 1'b1) begin failures++; $display("FAIL clamp got=%0d/%b exp=7/1", bus.values[17:12], c); end
    checks++; if (bus.commitIdx !== 2'd2) begin failures++; $display("FAIL clamp_idx got=%0d exp=2", bus.commitIdx); end
    press(12, 1, 1, c, c2);
    checks++; if (bus.setting !== 2'd0) begin failures++; $display("FAIL sel_wrap_up got=%0d exp=0", bus.setting); end
    press(13, 1, 1, c, c2);
    checks++; if (bus.setting !== 2'd2) begin failures++; $display("FAIL sel_wrap_dn got=%0d exp=2", bus.setting); end
  endtask

  task automatic test_pause();
    logic c, c2;
    press(12, 1, 1, c, c2);
    press(11, 1, 1, c, c2);
    checks++; if (bus.simState !== 2'd1) begin failures++; $display("FAIL to_sim got=%0d exp=1", bus.simState); end
    press(10, 1, 1, c, c2);
    checks++; if (bus.simState !== 2'd2) begin failures++; $display("FAIL to_pause got=%0d exp=2", bus.simState); end
    press(5, 1, 1, c, c2);
    press(15, 1, 1, c, c2);
    checks++; if (c !== 1'b0 || bus.values[5:0] !== 6'd42) begin failures++; $display("FAIL locked got=%b/%0d exp=0/42", c, bus.values[5:0]); end
    press(13, 1, 1, c, c2);
    press(5, 1, 1, c, c2);
    press(15, 1, 1, c, c2);
    checks++; if (c !== 1'b1 || bus.values[17:12] !== 6'd5) begin failures++; $display("FAIL live_edit got=%b/%0d exp=1/5", c, bus.values[17:12]); end
    press(10, 1, 1, c, c2);
    checks++; if (bus.simState !== 2'd3) begin failures++; $display("FAIL to_ending got=%0d exp=3", bus.simState); end
    press(11, 1, 1, c, c2);
    checks++; if (bus.simState !== 2'd0) begin failures++; $display("FAIL to_start got=%0d exp=0", bus.simState); end
  endtask

  task automatic test_back_to_back();
    logic c, c2;
    press(1, 1, 1, c, c2);
    press(2, 1, 1, c, c2);
    checks++; if (bus.entry !== 6'd12) begin failures++; $display("FAIL b2b got=%0d exp=12", bus.entry); end
    press(14, 1, 1, c, c2);
  endtask

  task automatic test_reset_mid();
    logic c, c2;
    press(3, 1, 1, c, c2);
    press(1, 1, 1, c, c2);
    checks++; if (bus.entry !== 6'd31) begin failures++; $display("FAIL pre_rst got=%0d exp=31", bus.entry); end
    @(negedge clk); rst = 1'b1;
    bus.buttonBus = 4'd5; bus.pressed = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.entry !== 6'd0 || bus.values !== 18'd0 || bus.simState !== 2'd0 || bus.commit !== 1'b0) begin
      failures++; $display("FAIL mid_rst got=%0d/%h/%0d/%b exp=0/0/0/0", bus.entry, bus.values, bus.simState, bus.commit);
    end
    @(negedge clk); rst = 1'b0; m_reset();
    repeat (3) @(posedge clk); #1;
    checks++; if (bus.entry !== 6'd0) begin failures++; $display("FAIL held_rst got=%0d exp=0", bus.entry); end
    @(negedge clk); bus.pressed = 1'b0;
    press(5, 1, 1, c, c2);
    checks++; if (bus.entry !== 6'd5) begin failures++; $display("FAIL rearm got=%0d exp=5", bus.entry); end
    press(14, 1, 1, c, c2);
  endtask

  task automatic test_random();
    logic c, c2;
    int k;
    for (int n = 0; n < 400; n++) begin
      if (n % 25 == 0) begin
        for (int i = 0; i < N; i++) mx[i] = $urandom_range(0, 63);
        set_max();
      end
      k = $urandom_range(0, 19);
      if (k >= 10) k = $urandom_range(10, 15);
      press(k, $urandom_range(1, 3), $urandom_range(1, 2), c, c2);
      checks++; if (bus.simState !== 2'(m_st) || bus.setting !== 2'(m_sel) || bus.entry !== 6'(m_ent)) begin
        failures++; $display("FAIL rnd_ctl n=%0d key=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", n, k, bus.simState, bus.setting, bus.entry, m_st, m_sel, m_ent);
      end
      checks++; if (c !== m_commit || c2 !== 1'b0 || (m_commit && bus.commitIdx !== 2'(m_idx))) begin
        failures++; $display("FAIL rnd_commit n=%0d got=%b%b/%0d exp=%b0/%0d", n, c, c2, bus.commitIdx, m_commit, m_idx);
      end
      for (int i = 0; i < N; i++) begin
        checks++; if (bus.values[i*VW +: VW] !== 6'(m_vals[i])) begin
          failures++; $display("FAIL rnd_val%0d n=%0d got=%0d exp=%0d", i, n, bus.values[i*VW +: VW], m_vals[i]);
        end
      end
    end
  endtask

`ifdef AUTO_RESTART_EN
  task automatic test_auto_restart();
    logic c, c2;
    int t;
    for (int i = 0; i < 4 && m_st != 2; i++) press(m_st == 1 ? 10 : 11, 1, 1, c, c2);
    @(negedge clk); bus.buttonBus = 4'd10; bus.pressed = 1'b1;
    @(posedge clk); #1;
    m_event(10);
    @(negedge clk); bus.pressed = 1'b0;
    t = 0;
    while (bus.simState == 2'd3 && t <= TO + 20) begin
      @(posedge clk); #1;
      t++;
    end
    m_st = 0; m_ent = 0; m_cnt = 0;
    checks++; if (t !== TO || bus.simState !== 2'd0) begin failures++; $display("FAIL auto_restart got=%0d/%0d exp=%0d/0", t, bus.simState, TO); end
  endtask
`endif

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_entry();
    test_hold();
    test_clamp();
    test_pause();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef AUTO_RESTART_EN
    test_auto_restart();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sim_config_ctrl.md
# sim_config_ctrl

Parametrised successor to the elevator simulator's central control FSM. Decodes keypad presses into four run states (START/SIM/PAUSE/ENDING), runs multi-digit decimal entry, and commits saturated values into a bank of NUM_SETTINGS registers. Unlike the previous generation, it acts once per press edge, supports mid-run editing of selected settings in PAUSE, clamps each setting to its own limit, and optionally auto-restarts from ENDING. It sits between the synchronised keypad encoder and the simulation core.

## Interface
- NUM_SETTINGS, 3: number of setting registers; legal range 2..8.
- VAL_W, 6: width of each setting value and of the entry accumulator.
- MAX_DIGITS, 2: maximum number of digits accepted per entry.
- LIVE_MASK, 3'b100: bit i set means setting i is editable in PAUSE.
- RESET_VALS, 0: NUM_SETTINGS*VAL_W packed reset values; setting i occupies [i*VAL_W +: VAL_W].
- TIMEOUT, 1000: ENDING auto-restart delay in cycles; used only with AUTO_RESTART_EN.
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous reset, active-high.
- buttonBus  in  4  key code: 0-9 digits, A STOP, B RESUME, C UP, D DOWN, E ESCAPE, F ENTER.
- pressed  in  1  a key is currently held; buttonBus is valid while high.
- maxVals  in  NUM_SETTINGS*VAL_W  per-setting upper clamp, packed like RESET_VALS.
- simState  out  2  0 START, 1 SIM, 2 PAUSE, 3 ENDING.
- setting  out  $clog2(NUM_SETTINGS)  currently selected setting index.
- entry  out  VAL_W  current digit accumulator.
- values  out  NUM_SETTINGS*VAL_W  committed setting registers.
- commit  out  1  one-cycle pulse when a value is written.
- commitIdx  out  $clog2(NUM_SETTINGS)  index written; valid with commit.

## Operation
- Press event: pressed_q registers pressed. An event fires on cycles with pressed=1 and pressed_q=0, using that cycle's buttonBus. Holding a key produces exactly one event.
- State machine, transitions on events only:
  - START: RESUME goes to SIM.
  - SIM: STOP goes to PAUSE.
  - PAUSE: RESUME goes to SIM; STOP goes to ENDING.
  - ENDING: RESUME goes to START.
  - Unencodable states are unreachable.
- Edit window:
  - In START, every setting is editable.
  - In PAUSE, only settings with LIVE_MASK[setting]=1 are editable.
  - In SIM and ENDING, nothing is editable.
- Digit event inside an edit window:
  - candidate = entry*10 + digit, computed at VAL_W+4 bits.
  - The accumulator takes the candidate only if candidate <= 2^VAL_W-1 and digit count < MAX_DIGITS.
  - Otherwise the digit is ignored; entry and the digit count are unchanged.
- ENTER inside an edit window: values[setting] gets min(entry, maxVals[setting]); commit=1 and commitIdx=setting on the next cycle. Committing an empty entry writes 0.
- ESCAPE, or ENTER outside a window: no write.
- UP: setting = (setting+1) mod NUM_SETTINGS. DOWN: setting = (setting-1) mod NUM_SETTINGS. Selection changes in every state.
- entry and the digit count clear to 0 on: ENTER, ESCAPE, UP, DOWN, any simState change, and entering a non-editable setting.
- STOP and RESUME in START/PAUSE do not commit.

## Timing
- Reset values: simState=0, setting=0, entry=0, digit count=0, values=RESET_VALS, commit=0, commitIdx=0, pressed_q=0, timeout counter=0.
- Latency: every output updates on the clock edge after the event cycle (1 cycle). commit is high for exactly one cycle.
- pressed held high across reset release: no event fires until pressed drops and rises again.
- A reset during entry discards the partial entry. Committed values return to RESET_VALS.
- Changing maxVals affects only later commits. Stored values are never re-clamped.
- The event detector has no back-to-back limit. An event every other cycle is legal.

## Configuration
- AUTO_RESTART_EN defined:
  - A counter of width $clog2(TIMEOUT+1) counts from entry to ENDING.
  - After TIMEOUT cycles in ENDING with no event, simState goes to START.
  - A RESUME event goes to START immediately.
  - Any other event in ENDING reloads the counter.
  - The counter is cleared outside ENDING.
- AUTO_RESTART_EN undefined: the counter is not built, and ENDING exits only on RESUME.

## Test plan
- Reset, then keys 4, 2, ENTER in START with maxVals[0]=63: values[0]=42, commit pulses once with commitIdx=0, entry returns to 0.
- Key 7 held for 20 cycles: entry=7, not 77. After release, 7 again: entry=77 saturates? With VAL_W=6, 77>63, so entry stays 7.
- setting=2, maxVals[2]=7, keys 9, ENTER: values[2]=7. UP from setting 2 gives setting 0; DOWN from 0 gives 2.
- RESUME, STOP (PAUSE); setting 0 (LIVE_MASK bit 0 clear), keys 5, ENTER: no commit, values[0] unchanged. Same sequence at setting 2: values[2]=5.
- PAUSE, STOP goes to ENDING; RESUME goes to START. With AUTO_RESTART_EN and TIMEOUT=10: START 10 cycles after entering ENDING; a digit event at cycle 5 delays return to cycle 15.
- Keys 3, 1 then assert rst for one cycle: entry=0, values=RESET_VALS, simState=START, no commit pulse.
